// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues in-order imem requests under a credit limit
// and buffers {pc, inst} pairs in a FIFO whose head feeds execute.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_if,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    output logic [31:0] inst_fetch,
    output logic [31:0] pc_out_fetch
);
    localparam int          AW  = $clog2(DEPTH);
    localparam int          CW  = AW + 1;
    localparam logic [31:0] NOP = 32'h0000_0033;

    logic [31:0]   pc_req;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] fifo_count;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [31:0]   fifo_pc   [DEPTH];
    logic [31:0]   fifo_inst [DEPTH];

    logic [CW:0]   credit_used;
    logic [CW-1:0] live_cnt;
    logic [31:0]   rsp_pc;
    logic          req_fire;
    logic          rsp_fire;
    logic          push;
    logic          pop;

    assign credit_used    = {1'b0, outstanding} + {1'b0, fifo_count};
    assign imem_req_valid = rst && !br_taken && (credit_used < (CW+1)'(DEPTH));
    assign imem_req_addr  = pc_req;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_fire       = imem_rsp_valid && (outstanding != '0);

    // Live in-flight PCs are contiguous and end at pc_req-4, so the oldest
    // one is derived from the live count instead of being stored.
    assign live_cnt = outstanding - drop_cnt;
    assign rsp_pc   = pc_req - (32'(live_cnt) << 2);
    assign push     = rsp_fire && (drop_cnt == '0);
    assign pop      = (fifo_count != '0) && !stall_if;

    assign inst_valid   = (fifo_count != '0);
    assign inst_fetch   = inst_valid ? fifo_inst[rd_ptr] : NOP;
    assign pc_out_fetch = inst_valid ? fifo_pc[rd_ptr] : 32'h0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_req      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            fifo_count  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else if (br_taken) begin
            // Everything still in flight after this cycle is stale.
            pc_req      <= br_target;
            outstanding <= outstanding - CW'(rsp_fire);
            drop_cnt    <= outstanding - CW'(rsp_fire);
            fifo_count  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            if (req_fire) begin
                pc_req <= pc_req + 32'd4;
            end
            outstanding <= outstanding + CW'(req_fire) - CW'(rsp_fire);
            if (rsp_fire && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - CW'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst && !br_taken && push) begin
            fifo_pc[wr_ptr]   <= rsp_pc;
            fifo_inst[wr_ptr] <= imem_rsp_data;
        end
    end

endmodule
